// File: rtl/multi_mode_ctrl_pkg.sv
// Purpose: shared types and helpers for the multi-mode controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e (RUN, BANNER) and idx_w(), the width of a mode index.
package multi_mode_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    BANNER = 1'b1
  } state_e;

  // Width of a mode index. Never below one bit, so that a port or register
  // built from it always exists.
  function automatic int idx_w(input int n_modes);
    return (n_modes > 1) ? $clog2(n_modes) : 1;
  endfunction

endpackage

// File: rtl/multi_mode_ctrl_if.sv
// Purpose: groups the button, mode and display signals of the mode controller.
// Latency: n/a (wiring only).
// Backpressure: n/a.
// Ports: master drives btn_pe/btn_next/btn_prev/mode_en/alarm_req/value_in;
//        slave drives btn_out/value_out/mode_idx/mode_onehot/banner.
interface multi_mode_ctrl_if #(
  parameter int N_MODES = 3,
  parameter int N_BTN   = 4,
  parameter int VALUE_W = 16
);
  import multi_mode_ctrl_pkg::*;

  localparam int IDX_W = idx_w(N_MODES);

  logic [N_BTN-1:0]           btn_pe;
  logic                       btn_next;
  logic                       btn_prev;
  logic [N_MODES-1:0]         mode_en;
  logic [N_MODES-1:0]         alarm_req;
  logic [N_MODES*VALUE_W-1:0] value_in;
  logic [N_MODES*N_BTN-1:0]   btn_out;
  logic [VALUE_W-1:0]         value_out;
  logic [IDX_W-1:0]           mode_idx;
  logic [N_MODES-1:0]         mode_onehot;
  logic                       banner;

  modport master (
    output btn_pe, btn_next, btn_prev, mode_en, alarm_req, value_in,
    input  btn_out, value_out, mode_idx, mode_onehot, banner
  );

  modport slave (
    input  btn_pe, btn_next, btn_prev, mode_en, alarm_req, value_in,
    output btn_out, value_out, mode_idx, mode_onehot, banner
  );

endinterface

// File: rtl/multi_mode_ctrl_cycle_timer.sv
// Purpose: loadable down-counter; done flags the final counted cycle.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; a load always overrides the running count.
// Ports: clk, reset_p (async, active high), load, load_val in; done out.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  // High while the count is 1: the next edge takes it to 0.
  assign done = (count_q == W'(1));

endmodule

// File: rtl/multi_mode_ctrl.sv
// Purpose: holds the current application mode and routes buttons and display to it.
// Latency: mode changes land one cycle after their cause; btn_out/value_out are combinational.
// Backpressure: none; btn_pe pulses arriving while the banner is shown are dropped.
// Ports: clk, reset_p (async, active high); bus (slave): btn_pe, btn_next, btn_prev,
//        mode_en, alarm_req, value_in in; btn_out, value_out, mode_idx, mode_onehot, banner out.
module multi_mode_ctrl
  import multi_mode_ctrl_pkg::*;
#(
  parameter int N_MODES    = 3,
  parameter int N_BTN      = 4,
  parameter int VALUE_W    = 16,
  parameter int BANNER_CYC = 50_000_000,
  parameter int IDLE_CYC   = 0
) (
  input logic              clk,
  input logic              reset_p,
  multi_mode_ctrl_if.slave bus
);

  localparam int IDX_W  = idx_w(N_MODES);
  localparam int CNT_W  = $clog2(BANNER_CYC + 1);
  localparam int IDLE_W = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     mode_q, mode_d;
  logic [N_MODES-1:0]   onehot;
  logic [N_MODES-1:0]   en_eff;
  logic [N_MODES-1:0]   alarm_q;
  logic [N_MODES-1:0]   alarm_rise;
  logic [2*N_MODES-1:0] en_rot;
  logic [IDX_W-1:0]     nxt_idx, prv_idx, alarm_idx;
  logic                 nxt_found, prv_found, alarm_hit;
  logic                 cur_en, cur_alarm, activity, idle_to;
  logic                 mode_chg, tmr_done;
  logic [IDLE_W-1:0]    idle_q;

  assign onehot     = N_MODES'(1) << mode_q;
  // Mode 0 is always selectable regardless of its enable bit.
  assign en_eff     = bus.mode_en | N_MODES'(1);
  assign cur_en     = |(en_eff & onehot);
  assign cur_alarm  = |(bus.alarm_req & onehot);
  assign activity   = (|bus.btn_pe) | bus.btn_next | bus.btn_prev;
  assign alarm_rise = bus.alarm_req & ~alarm_q & en_eff & ~onehot;

  // Enables rotated so that en_rot[i] is the enable of (mode_q + i) mod N.
  // Looking downward, (mode_q - i) mod N lands at en_rot[N - i].
  assign en_rot = {en_eff, en_eff} >> mode_q;

  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = mode_q;
    prv_found = 1'b0;
    prv_idx   = mode_q;
    for (int i = 1; i < N_MODES; i++) begin
      if (!nxt_found && en_rot[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'((int'(mode_q) + i) % N_MODES);
      end
      if (!prv_found && en_rot[N_MODES - i]) begin
        prv_found = 1'b1;
        prv_idx   = IDX_W'((int'(mode_q) + N_MODES - i) % N_MODES);
      end
    end
  end

  // Lowest-index rising alarm wins; scanning downward leaves it as the last write.
  always_comb begin
    alarm_hit = 1'b0;
    alarm_idx = '0;
    for (int k = N_MODES - 1; k >= 0; k--) begin
      if (alarm_rise[k]) begin
        alarm_hit = 1'b1;
        alarm_idx = IDX_W'(k);
      end
    end
  end

  assign idle_to = (IDLE_CYC > 0) && (idle_q == IDLE_W'(IDLE_CYC)) &&
                   (mode_q != '0) && !cur_alarm;

  // Mode selection, highest priority first.
  always_comb begin
    mode_d = mode_q;
    if (!cur_en) begin
      mode_d = '0;
    end else if (alarm_hit) begin
      mode_d = alarm_idx;
    end else if (bus.btn_next && !bus.btn_prev && nxt_found) begin
      mode_d = nxt_idx;
    end else if (bus.btn_prev && !bus.btn_next && prv_found) begin
      mode_d = prv_idx;
    end else if (idle_to) begin
      mode_d = '0;
    end
  end

  assign mode_chg = (mode_d != mode_q);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      mode_q  <= '0;
      alarm_q <= '0;
      idle_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      alarm_q <= bus.alarm_req;
      if (activity || mode_chg) begin
        idle_q <= '0;
      end else if (idle_q != IDLE_W'(IDLE_CYC)) begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Every mode change (re)enters BANNER; the timer is reloaded on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mode_chg) state_d = BANNER;
      end
      BANNER: begin
        if (mode_chg)      state_d = BANNER;
        else if (tmr_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  cycle_timer #(
    .W(CNT_W)
  ) u_banner_tmr (
    .clk      (clk),
    .reset_p  (reset_p),
    .load     (mode_chg),
    .load_val (CNT_W'(BANNER_CYC)),
    .done     (tmr_done)
  );

  // While the banner is up, the display shows the mode number and buttons go nowhere.
  always_comb begin
    bus.btn_out   = '0;
    bus.value_out = VALUE_W'(mode_q);
    if (state_q == RUN) begin
      for (int k = 0; k < N_MODES; k++) begin
        if (mode_q == IDX_W'(k)) begin
          bus.btn_out[k*N_BTN +: N_BTN] = bus.btn_pe;
          bus.value_out                 = bus.value_in[k*VALUE_W +: VALUE_W];
        end
      end
    end
  end

  assign bus.banner      = (state_q == BANNER);
  assign bus.mode_idx    = mode_q;
  assign bus.mode_onehot = onehot;

endmodule
